// File: rtl/filtros_pkg.sv
// Shared definitions for the row-buffer filter path: controller state encoding
// and the helper that builds per-buffer enable masks.
package filtros_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } estado_t;

  // Widest enable mask any controller instance may drive.
  localparam int MASK_W_MAX = 16;

  // Mask with the n lowest bits set (n saturates at MASK_W_MAX).
  function automatic logic [MASK_W_MAX-1:0] mascara_baja(input int n);
    logic [MASK_W_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W_MAX; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/control_buffer_filas_if.sv
// Handshake and buffer-control bundle between the pixel source, the row
// buffer units and the row-buffer controller.
interface control_buffer_filas_if #(
  parameter int NUM_BUFFERS = 3
);
  logic                   start;
  logic                   frame_end;
  logic                   pixel_valid;
  logic [NUM_BUFFERS-1:0] fifo_full;
  logic                   pixel_ready;
  logic                   write_req;
  logic                   read_req;
  logic [NUM_BUFFERS-1:0] write_en;
  logic [NUM_BUFFERS-1:0] read_en;
  logic                   window_valid;
  logic                   buffer_flush;
  logic                   overflow;

  // Source / buffer side: drives frame control and observes the controller.
  modport master (
    output start, frame_end, pixel_valid, fifo_full,
    input  pixel_ready, write_req, read_req, write_en, read_en,
           window_valid, buffer_flush, overflow
  );

  // Controller side.
  modport slave (
    input  start, frame_end, pixel_valid, fifo_full,
    output pixel_ready, write_req, read_req, write_en, read_en,
           window_valid, buffer_flush, overflow
  );
endinterface

// File: rtl/control_buffer_filas_contador_columna.sv
// Wrap-around column counter: counts enabled cycles 0..MODULO-1 and flags the
// last column so the controller can advance its fill stage.
module contador_columna #(
  parameter int WIDTH  = 3,
  parameter int MODULO = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/control_buffer_filas.sv
// Row-buffer controller: fills a cascade of line buffers one row at a time,
// then streams with every buffer reading and writing to form pixel columns.
module control_buffer_filas
  import filtros_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int BITS_FOR_DATA = 3,
  parameter int NUM_BUFFERS   = 3,
  parameter int ROW_LENGTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  control_buffer_filas_if.slave  bus
);

  localparam int SW = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_BUFFERS - 1);

  if (DATA_WIDTH < 1 || NUM_BUFFERS < 1 || NUM_BUFFERS > MASK_W_MAX ||
      ROW_LENGTH < 2 || ROW_LENGTH > (1 << BITS_FOR_DATA)) begin : g_bad_params
    $error("control_buffer_filas: illegal parameter combination");
  end

  estado_t                  state, state_d;
  logic [SW-1:0]            stage, stage_d;
  logic [BITS_FOR_DATA-1:0] col;
  logic                     col_tc;
  logic                     unused_col;

  logic                     pixel_ready;
  logic                     accept;
  logic                     fe_hit;
  logic                     start_hit;
  logic                     row_done;
  logic                     fill_done;

  logic [NUM_BUFFERS-1:0]   write_en_q, write_en_d;
  logic [NUM_BUFFERS-1:0]   read_en_q, read_en_d;
  logic                     window_valid_q, window_valid_d;
  logic                     buffer_flush_q, buffer_flush_d;
  logic                     overflow_q, overflow_d;
  logic [MASK_W_MAX-1:0]    wmask, rmask;

  assign pixel_ready = (state != IDLE);
  assign fe_hit      = bus.frame_end && (state != IDLE);
  assign start_hit   = bus.start && (state == IDLE);
  // frame_end wins over a pixel offered in the same cycle.
  assign accept      = bus.pixel_valid && pixel_ready && !bus.frame_end;
  assign row_done    = accept && (state == FILL) && col_tc;
  assign fill_done   = row_done && (stage == LAST_STAGE);

  // Only the terminal count drives control; the raw index is kept for debug.
  assign unused_col  = ^col;

  contador_columna #(
    .WIDTH  (BITS_FOR_DATA),
    .MODULO (ROW_LENGTH)
  ) u_columna (
    .clk   (clk),
    .reset (reset),
    .clr   (fe_hit || start_hit),
    .en    (accept && (state == FILL)),
    .count (col),
    .tc    (col_tc)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      stage          <= '0;
      write_en_q     <= '0;
      read_en_q      <= '0;
      window_valid_q <= 1'b0;
      buffer_flush_q <= 1'b1;
      overflow_q     <= 1'b0;
    end else begin
      state          <= state_d;
      stage          <= stage_d;
      write_en_q     <= write_en_d;
      read_en_q      <= read_en_d;
      window_valid_q <= window_valid_d;
      buffer_flush_q <= buffer_flush_d;
      overflow_q     <= overflow_d;
    end
  end

  // Next state and fill stage
  always_comb begin
    state_d = state;
    stage_d = stage;
    unique case (state)
      IDLE: begin
        if (start_hit) begin
          state_d = FILL;
          stage_d = '0;
        end
      end
      FILL: begin
        if (fe_hit) begin
          state_d = IDLE;
          stage_d = '0;
        end else if (fill_done) begin
          state_d = STREAM;
          stage_d = '0;
        end else if (row_done) begin
          stage_d = stage + 1'b1;
        end
      end
      STREAM: begin
        if (fe_hit) begin
          state_d = IDLE;
          stage_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        stage_d = '0;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    wmask      = mascara_baja(int'(stage_d) + 1);
    rmask      = mascara_baja(int'(stage_d));
    write_en_d = '0;
    read_en_d  = '0;
    unique case (state_d)
      FILL: begin
        write_en_d = wmask[NUM_BUFFERS-1:0];
        read_en_d  = rmask[NUM_BUFFERS-1:0];
      end
      STREAM: begin
        write_en_d = '1;
        read_en_d  = '1;
      end
      default: begin
        write_en_d = '0;
        read_en_d  = '0;
      end
    endcase
    // Buffer read data appears one cycle after the shared read request.
    window_valid_d = (state == STREAM) && accept;
    buffer_flush_d = fe_hit;
    overflow_d     = overflow_q ||
                     (accept && |(bus.fifo_full & write_en_q & ~read_en_q));
  end

  assign bus.pixel_ready  = pixel_ready;
  assign bus.write_req    = accept;
  assign bus.read_req     = accept;
  assign bus.write_en     = write_en_q;
  assign bus.read_en      = read_en_q;
  assign bus.window_valid = window_valid_q;
  assign bus.buffer_flush = buffer_flush_q;
  assign bus.overflow     = overflow_q;

endmodule
